// File: rtl/network_pkg.sv
// Shared RAM bus constants, arbiter state encoding and requester indices.
package network_pkg;

  localparam int RAM_ADDR_W = 23;
  localparam int RAM_DATA_W = 16;

  localparam logic RAM_READ  = 1'b0;
  localparam logic RAM_WRITE = 1'b1;

  localparam int REQ_LOADER = 0;
  localparam int REQ_GA     = 1;
  localparam int REQ_HOST   = 2;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DONE,
    ARB_RELEASE
  } arb_state_e;

  // Index width that stays legal for a single-client build.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_bus_arbiter_if.sv
// Client request/ack handshake plus the shared RAM bus, as seen by the arbiter.
interface ram_bus_arbiter_if
  import network_pkg::*;
#(
  parameter int REQUESTERS = 3
);

  // Client side
  logic [REQUESTERS-1:0]            reqEnable;
  logic [REQUESTERS-1:0]            req;
  logic [REQUESTERS-1:0]            reqWrite;
  logic [REQUESTERS*RAM_ADDR_W-1:0] reqAddr;
  logic [REQUESTERS*RAM_DATA_W-1:0] reqWdata;
  logic [REQUESTERS-1:0]            ack;
  logic                             ackErr;
  logic [RAM_DATA_W-1:0]            rdata;
  logic                             busy;

  // RAM controller side
  logic [RAM_ADDR_W-1:0]            ramBusAddr;
  logic [RAM_DATA_W-1:0]            ramBusDataIn;
  logic                             ramLatch;
  logic                             ramInstruction;
  logic                             ramReady;
  logic [RAM_DATA_W-1:0]            ramBusDataOut;

  // The arbiter: serves client requests and owns the RAM bus.
  modport slave (
    input  reqEnable, req, reqWrite, reqAddr, reqWdata, ramReady, ramBusDataOut,
    output ack, ackErr, rdata, busy, ramBusAddr, ramBusDataIn, ramLatch, ramInstruction
  );

  // The environment: clients and RAM controller.
  modport master (
    output reqEnable, req, reqWrite, reqAddr, reqWdata, ramReady, ramBusDataOut,
    input  ack, ackErr, rdata, busy, ramBusAddr, ramBusDataIn, ramLatch, ramInstruction
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first eligible index after ptr, wrapping.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  // Scan from farthest to nearest so the nearest eligible after ptr is kept last.
  always_comb begin
    int idx;
    // NOTE: every output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    idx    = 0;
    valid  = 1'b0;
    winner = '0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(ptr) + i) % N;
      if (eligible[idx]) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Single registered owner of the RAM bus, shared round-robin between clients.
module ram_bus_arbiter
  import network_pkg::*;
#(
  parameter int REQUESTERS = 3,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8
) (
  input logic              clk,
  input logic              rst_n,
  ram_bus_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(REQUESTERS);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      winner_q, winner_d;
  logic [TO_W-1:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  write_q, write_d;
  logic [RAM_ADDR_W-1:0] addr_q, addr_d;
  logic [RAM_DATA_W-1:0] wdata_q, wdata_d;
  logic [RAM_DATA_W-1:0] rdata_q, rdata_d;

  logic [REQUESTERS-1:0] eligible;
  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;

  assign eligible = bus.req & bus.reqEnable;

  rr_pick #(
    .N     (REQUESTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .valid    (pick_valid),
    .winner   (pick_idx)
  );

  // State and datapath registers; reset aborts any transaction without an ack.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample the pre-edge value, independent of statement order.
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      write_q  <= RAM_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next state plus the registered request, counter and read-data updates.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          winner_d = pick_idx;
          write_d  = bus.reqWrite[pick_idx];
          addr_d   = bus.reqAddr[int'(pick_idx)*RAM_ADDR_W +: RAM_ADDR_W];
          wdata_d  = bus.reqWdata[int'(pick_idx)*RAM_DATA_W +: RAM_DATA_W];
          err_d    = 1'b0;
          state_d  = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        cnt_d   = '0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        // Saturate so a long stall can never wrap back below TIMEOUT.
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (bus.ramReady) begin
          if (write_q == RAM_READ) rdata_d = bus.ramBusDataOut;
          state_d = ARB_DONE;
        end else if (cnt_d == TO_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        ptr_d   = winner_q;
        state_d = ARB_RELEASE;
      end
      ARB_RELEASE: begin
        // A completed access must see ready drop before the next grant can use it.
        if (err_q || !bus.ramReady) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.ack = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      bus.ack[i] = (state_q == ARB_DONE) && (winner_q == IDX_W'(i));
    end
    bus.ackErr   = (state_q == ARB_DONE) && err_q;
    bus.ramLatch = (state_q == ARB_ISSUE);
    bus.busy     = (state_q != ARB_IDLE);
  end

  assign bus.rdata          = rdata_q;
  assign bus.ramBusAddr     = addr_q;
  assign bus.ramBusDataIn   = wdata_q;
  assign bus.ramInstruction = write_q;

endmodule
